gmii_frame_gen: RTL
===================

Name: gmii_frame_gen

Overview:
Parametrised multi-channel Ethernet frame stimulus engine. It replaces the fixed per-port RGMII stimulus registers in the system testbench flow with a synthesisable GMII-side generator. N independent channels emit preamble, SFD, header, pattern payload, CRC-32 FCS and inter-frame gap under one shared start/busy/done handshake. It sits between the testbench control logic and the per-port GMII-to-RGMII adapters.

Parameters:
NUM_CHANNELS, 4, number of GMII TX channels (1..8)
IFG_BYTES, 12, idle cycles between frames on a channel (minimum 1)
CNT_WIDTH, 16, width of frame_count and per-channel frames_sent counters

Ports:
clk_in  input  1  byte clock (125 MHz GMII), sole clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; samples frame_len, frame_count, chan_mask
frame_len  input  11  bytes from DA through end of payload, excluding FCS
frame_count  input  CNT_WIDTH  frames per enabled channel; 0 means none
chan_mask  input  NUM_CHANNELS  channel enables
busy  output  1  high while any sampled channel is active
done  output  1  one-cycle pulse when the last active channel finishes
gmii_txd  output  8*NUM_CHANNELS  channel c on bits [8c+7:8c]
gmii_tx_en  output  NUM_CHANNELS  frame valid per channel
frames_sent  output  CNT_WIDTH*NUM_CHANNELS  completed frames per channel since last start

Behaviour:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high.
- Reset values: busy=0, done=0, gmii_txd=0, gmii_tx_en=0, frames_sent=0, all channel FSMs in IDLE.
  - Reset mid-frame aborts immediately. tx_en drops the cycle after reset is sampled, and no done pulse is issued.
- start handling:
  - start with busy=0 latches the inputs and clears frames_sent.
  - Each channel with chan_mask[c]=1 and frame_count!=0 leaves IDLE on the next cycle. Its first preamble byte appears 1 cycle after start.
  - busy rises the cycle after start.
  - start while busy=1 is ignored.
  - start with an empty effective mask (mask=0 or frame_count=0) gives busy unchanged at 0 and a done pulse 1 cycle after start.
- Length clamp: frame_len<60 is treated as 60; frame_len>1514 is treated as 1514. The clamp is applied at start.
- Per-channel FSM states: IDLE -> PRE (7 cycles, 0x55) -> SFD (1 cycle, 0xD5) -> DATA (L cycles) -> FCS (4 cycles) -> IFG (IFG_BYTES cycles, tx_en=0, txd=0).
  - After IFG: back to PRE if frames remain, otherwise IDLE.
  - gmii_tx_en=1 exactly in PRE, SFD, DATA and FCS, so a frame occupies 8+L+4 contiguous cycles.
- DATA bytes, with index i from 0 and frame number f from 0:
  - i=0..5 (DA): 02 00 00 00 00 c.
  - i=6..11 (SA): 02 00 00 00 01 c.
  - i=12,13 (EtherType): 0x88 0xB5.
  - i>=14: (i-14+f) mod 256.
- FCS: IEEE 802.3 CRC-32 over DATA bytes only.
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, final value inverted.
  - Transmitted least-significant byte first.
  - The CRC is computed combinationally per byte and registered, so the FCS is available with no bubble after the last DATA byte.
- frames_sent[c] increments on the last FCS cycle of each frame.
- Completion:
  - A channel finishes when its final IFG completes.
  - busy falls, and done pulses, on the cycle after the last active channel returns to IDLE.
  - If several channels finish in the same cycle, only one done pulse is issued.
- Channels share the launch cycle and run in lockstep, but state is held per channel so that differing masks do not interact.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
1. Reset, then start with frame_len=60, frame_count=1, chan_mask=4'b0001.
   - ch0 tx_en is high for exactly 72 cycles; bytes are 55x7, D5, 02 00 00 00 00 00, 02 00 00 00 01 00, 88 B5, then 00..2D.
   - The FCS matches a software CRC-32 reference.
   - done pulses 84 cycles after the first preamble byte; frames_sent[0]=1.
2. frame_len=100, frame_count=3, chan_mask=4'b1111.
   - All four channels emit identical timing.
   - Frame f payload byte 14 = f (00, 01, 02).
   - The IFG between frames is exactly 12 idle cycles.
   - frames_sent = 3 on every channel; one done pulse.
3. frame_len=20 and frame_len=2000.
   - tx_en high for 72 and 1526 cycles respectively, matching clamps to 60 and 1514.
4. A second start while busy, issued 10 cycles into test 2.
   - No change in output stream and frames_sent; exactly one done pulse.
5. chan_mask=0, then frame_count=0 with chan_mask=4'b1111.
   - busy stays 0, done pulses 1 cycle after each start, and all tx_en stay 0.
6. Assert reset during DATA of frame 1 on all channels.
   - tx_en=0 on the next cycle, frames_sent=0, and no done pulse.
   - A new start then produces a clean frame beginning with preamble.

Source files
------------

// File: rtl/gmii_frame_gen.sv
// gmii_frame_gen: multi-channel GMII Ethernet frame generator.
// Preamble, SFD, header, pattern payload, CRC-32 FCS and IFG per channel.
module gmii_frame_gen #(
  parameter int NUM_CHANNELS = 4,
  parameter int IFG_BYTES    = 12,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              clk_in,
  input  logic                              reset,
  input  logic                              start,
  input  logic [10:0]                       frame_len,
  input  logic [CNT_WIDTH-1:0]              frame_count,
  input  logic [NUM_CHANNELS-1:0]           chan_mask,
  output logic                              busy,
  output logic                              done,
  output logic [8*NUM_CHANNELS-1:0]         gmii_txd,
  output logic [NUM_CHANNELS-1:0]           gmii_tx_en,
  output logic [CNT_WIDTH*NUM_CHANNELS-1:0] frames_sent
);

  localparam int NC = NUM_CHANNELS;
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
  localparam logic [10:0] LEN_MIN  = 11'd60;
  localparam logic [10:0] LEN_MAX  = 11'd1514;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_FCS,
    S_IFG
  } state_t;

  state_t               st_q   [NC];
  logic [10:0]          idx_q  [NC];
  logic [CNT_WIDTH-1:0] fnum_q [NC];
  logic [CNT_WIDTH-1:0] sent_q [NC];
  logic [31:0]          crc_q  [NC];
  logic [7:0]           txd_q  [NC];
  logic [NC-1:0]        en_q;

  logic [10:0]          len_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [10:0]          len_clamp;
  logic                 go;
  logic [NC-1:0]        launch;
  logic [NC-1:0]        fin;
  logic [NC-1:0]        live;

  // Frame body byte i of frame f on channel ch.
  function automatic logic [7:0] data_byte(
    input logic [10:0]          i,
    input logic [CNT_WIDTH-1:0] f,
    input logic [7:0]           ch
  );
    logic [10:0] p;
    p = i - 11'd14;
    case (i)
      11'd0, 11'd6:   data_byte = 8'h02;
      11'd5, 11'd11:  data_byte = ch;
      11'd10:         data_byte = 8'h01;
      11'd12:         data_byte = 8'h88;
      11'd13:         data_byte = 8'hB5;
      11'd1, 11'd2, 11'd3, 11'd4,
      11'd7, 11'd8, 11'd9:
                      data_byte = 8'h00;
      default:        data_byte = p[7:0] + f[7:0];
    endcase
  endfunction

  // One byte of reflected CRC-32 (poly 0xEDB88320).
  function automatic logic [31:0] crc_byte(
    input logic [31:0] crc,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = crc ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    crc_byte = r;
  endfunction

  assign go = start & ~busy;

  // Clamp the requested body length into the legal frame range.
  always_comb begin
    len_clamp = frame_len;
    if (frame_len < LEN_MIN) len_clamp = LEN_MIN;
    else if (frame_len > LEN_MAX) len_clamp = LEN_MAX;
  end

  // Per-channel launch, finish and next-cycle activity.
  always_comb begin
    launch = '0;
    fin    = '0;
    live   = '0;
    for (int c = 0; c < NC; c++) begin
      launch[c] = go & chan_mask[c] & (frame_count != '0);
      fin[c]    = (st_q[c] == S_IFG) &&
                  (idx_q[c] == IFG_LAST) &&
                  (sent_q[c] == count_q);
      live[c]   = launch[c] |
                  ((st_q[c] != S_IDLE) & ~fin[c]);
    end
  end

  // Channel FSMs, CRC, counters and the shared handshake.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      len_q   <= LEN_MIN;
      count_q <= '0;
      en_q    <= '0;
      for (int c = 0; c < NC; c++) begin
        st_q[c]   <= S_IDLE;
        idx_q[c]  <= '0;
        fnum_q[c] <= '0;
        sent_q[c] <= '0;
        crc_q[c]  <= '0;
        txd_q[c]  <= '0;
      end
    end else begin
      busy <= |live;
      done <= (busy | go) & ~(|live);
      if (go) begin
        len_q   <= len_clamp;
        count_q <= frame_count;
      end
      for (int c = 0; c < NC; c++) begin
        txd_q[c] <= 8'h00;
        en_q[c]  <= 1'b0;
        if (go) sent_q[c] <= '0;
        unique case (st_q[c])
          S_IDLE: begin
            if (launch[c]) begin
              st_q[c]   <= S_PRE;
              idx_q[c]  <= '0;
              fnum_q[c] <= '0;
              txd_q[c]  <= 8'h55;
              en_q[c]   <= 1'b1;
            end
          end
          S_PRE: begin
            en_q[c] <= 1'b1;
            if (idx_q[c] == 11'd6) begin
              st_q[c]  <= S_SFD;
              txd_q[c] <= 8'hD5;
            end else begin
              idx_q[c] <= idx_q[c] + 11'd1;
              txd_q[c] <= 8'h55;
            end
          end
          S_SFD: begin
            st_q[c]  <= S_DATA;
            idx_q[c] <= '0;
            en_q[c]  <= 1'b1;
            txd_q[c] <= data_byte(11'd0, fnum_q[c], 8'(c));
            crc_q[c] <= crc_byte(32'hFFFFFFFF,
                          data_byte(11'd0, fnum_q[c], 8'(c)));
          end
          S_DATA: begin
            en_q[c] <= 1'b1;
            if (idx_q[c] == len_q - 11'd1) begin
              st_q[c]  <= S_FCS;
              idx_q[c] <= '0;
              txd_q[c] <= ~crc_q[c][7:0];
            end else begin
              idx_q[c] <= idx_q[c] + 11'd1;
              txd_q[c] <= data_byte(idx_q[c] + 11'd1,
                            fnum_q[c], 8'(c));
              crc_q[c] <= crc_byte(crc_q[c],
                            data_byte(idx_q[c] + 11'd1,
                              fnum_q[c], 8'(c)));
            end
          end
          S_FCS: begin
            if (idx_q[c] == 11'd3) begin
              st_q[c]   <= S_IFG;
              idx_q[c]  <= '0;
              sent_q[c] <= sent_q[c] + 1'b1;
            end else begin
              idx_q[c] <= idx_q[c] + 11'd1;
              en_q[c]  <= 1'b1;
              txd_q[c] <= ~crc_q[c][15:8];
              crc_q[c] <= crc_q[c] >> 8;
            end
          end
          S_IFG: begin
            if (idx_q[c] == IFG_LAST) begin
              if (fin[c]) begin
                st_q[c] <= S_IDLE;
              end else begin
                st_q[c]   <= S_PRE;
                idx_q[c]  <= '0;
                fnum_q[c] <= fnum_q[c] + 1'b1;
                txd_q[c]  <= 8'h55;
                en_q[c]   <= 1'b1;
              end
            end else begin
              idx_q[c] <= idx_q[c] + 11'd1;
            end
          end
          default: st_q[c] <= S_IDLE;
        endcase
      end
    end
  end

  // Flatten per-channel registers onto the output buses.
  always_comb begin
    gmii_txd    = '0;
    frames_sent = '0;
    gmii_tx_en  = en_q;
    for (int c = 0; c < NC; c++) begin
      gmii_txd[8*c +: 8]                  = txd_q[c];
      frames_sent[CNT_WIDTH*c +: CNT_WIDTH] = sent_q[c];
    end
  end

endmodule
